// File: rtl/seven_seg_scanner_pkg.sv
// rtl/seven_seg_scanner_pkg.sv - shared segment patterns, slot states and decode helper
package seven_seg_scanner_pkg;

    // Full active-low byte for a dark digit, and where the decimal point lives in it
    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam int         SEG_DP_BIT = 7;

    // Active-low g..a patterns
    localparam logic [6:0] SEG7_BLANK = 7'b1111111;
    localparam logic [6:0] SEG7_0     = 7'b1000000;
    localparam logic [6:0] SEG7_1     = 7'b1111001;
    localparam logic [6:0] SEG7_2     = 7'b0100100;
    localparam logic [6:0] SEG7_3     = 7'b0110000;
    localparam logic [6:0] SEG7_4     = 7'b0011001;
    localparam logic [6:0] SEG7_5     = 7'b0010010;
    localparam logic [6:0] SEG7_6     = 7'b0000010;
    localparam logic [6:0] SEG7_7     = 7'b1111000;
    localparam logic [6:0] SEG7_8     = 7'b0000000;
    localparam logic [6:0] SEG7_9     = 7'b0010000;
    localparam logic [6:0] SEG7_A     = 7'b0001000;
    localparam logic [6:0] SEG7_B     = 7'b0000011;
    localparam logic [6:0] SEG7_C     = 7'b1000110;
    localparam logic [6:0] SEG7_D     = 7'b0100001;
    localparam logic [6:0] SEG7_E     = 7'b0000110;
    localparam logic [6:0] SEG7_F     = 7'b0001110;

    // Phase within one digit slot: anodes off first, then driven
    typedef enum logic {
        S_DEAD  = 1'b0,
        S_DRIVE = 1'b1
    } slot_state_t;

    // Codes 10..15 are letters only when hex display is enabled, otherwise dark
    function automatic logic [6:0] seg7_pattern(input logic [3:0] code, input logic hex_en);
        logic [6:0] pat;
        pat = SEG7_BLANK;
        case (code)
            4'h0:    pat = SEG7_0;
            4'h1:    pat = SEG7_1;
            4'h2:    pat = SEG7_2;
            4'h3:    pat = SEG7_3;
            4'h4:    pat = SEG7_4;
            4'h5:    pat = SEG7_5;
            4'h6:    pat = SEG7_6;
            4'h7:    pat = SEG7_7;
            4'h8:    pat = SEG7_8;
            4'h9:    pat = SEG7_9;
            4'hA:    pat = hex_en ? SEG7_A : SEG7_BLANK;
            4'hB:    pat = hex_en ? SEG7_B : SEG7_BLANK;
            4'hC:    pat = hex_en ? SEG7_C : SEG7_BLANK;
            4'hD:    pat = hex_en ? SEG7_D : SEG7_BLANK;
            4'hE:    pat = hex_en ? SEG7_E : SEG7_BLANK;
            4'hF:    pat = hex_en ? SEG7_F : SEG7_BLANK;
            default: pat = SEG7_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seven_seg_scanner_seg_decode.sv
// rtl/seven_seg_scanner_seg_decode.sv - combinational digit code to g..a segment decoder
module seg_decode
    import seven_seg_scanner_pkg::*;
#(
    parameter int HEX_MODE = 0
) (
    input  logic [3:0] i_code,
    output logic [6:0] o_seg7
);

    assign o_seg7 = seg7_pattern(i_code, HEX_MODE != 0);

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - multiplexed seven-segment scanner with frame-synchronous updates
module seven_seg_scanner
    import seven_seg_scanner_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int DEAD_CYCLES  = 2,
    parameter int BLINK_FRAMES = 250,
    parameter int HEX_MODE     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lzs_en,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam slot_state_t SLOT_START = (DEAD_CYCLES > 0) ? S_DEAD : S_DRIVE;

    logic [SLOT_W-1:0]       r_slot_cnt;
    logic [IDX_W-1:0]        r_scan_idx;
    slot_state_t             r_state;
    logic [FRM_W-1:0]        r_frame_cnt;
    logic                    r_blink_phase;
    logic                    r_frame_done;

    logic [4*NUM_DIGITS-1:0] r_pnd_digits;
    logic [NUM_DIGITS-1:0]   r_pnd_dp;
    logic [NUM_DIGITS-1:0]   r_pnd_blank;
    logic [NUM_DIGITS-1:0]   r_pnd_blink;
    logic                    r_pnd_lzs;
    logic                    r_pnd_dirty;

    logic [4*NUM_DIGITS-1:0] r_act_digits;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic [NUM_DIGITS-1:0]   r_act_blank;
    logic [NUM_DIGITS-1:0]   r_act_blink;
    logic                    r_act_lzs;
    logic                    r_live;

    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;

    logic                    w_slot_term;
    logic                    w_last_digit;
    logic                    w_boundary;
    logic                    w_commit;
    logic [SLOT_W-1:0]       w_slot_next;
    slot_state_t             w_next_state;
    logic [NUM_DIGITS-1:0]   w_supp;
    logic                    w_lead;
    logic [3:0]              w_code;
    logic                    w_dp_sel;
    logic                    w_dark_sel;
    logic [NUM_DIGITS-1:0]   w_an_sel;
    logic [6:0]              w_seg7;
    logic [7:0]              w_seg_next;
    logic [NUM_DIGITS-1:0]   w_an_next;

    assign w_slot_term  = (r_slot_cnt == SLOT_W'(REFRESH_DIV - 1));
    assign w_last_digit = (r_scan_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_boundary   = w_slot_term && w_last_digit;
    // A load on the boundary cycle itself is committed straight from the inputs
    assign w_commit     = w_boundary && (load || r_pnd_dirty);
    assign w_slot_next  = w_slot_term ? '0 : r_slot_cnt + SLOT_W'(1);
    assign w_next_state = (int'(w_slot_next) < DEAD_CYCLES) ? S_DEAD : S_DRIVE;

    // Slot/scan/frame counters and the per-slot dead/drive state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slot_cnt    <= '0;
            r_scan_idx    <= '0;
            r_state       <= SLOT_START;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_slot_cnt   <= w_slot_next;
            r_state      <= w_next_state;
            r_frame_done <= w_boundary;
            if (w_slot_term) begin
                r_scan_idx <= w_last_digit ? '0 : r_scan_idx + IDX_W'(1);
            end
            if (w_boundary) begin
                if (r_frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + FRM_W'(1);
                end
            end
        end
    end

    // Pending set: last load in a frame wins; dirty marks an uncommitted load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pnd_digits <= '0;
            r_pnd_dp     <= '0;
            r_pnd_blank  <= '1;
            r_pnd_blink  <= '0;
            r_pnd_lzs    <= 1'b0;
            r_pnd_dirty  <= 1'b0;
        end else begin
            if (load) begin
                r_pnd_digits <= digits;
                r_pnd_dp     <= dp;
                r_pnd_blank  <= blank_mask;
                r_pnd_blink  <= blink_mask;
                r_pnd_lzs    <= lzs_en;
            end
            if (w_commit) begin
                r_pnd_dirty <= 1'b0;
            end else if (load) begin
                r_pnd_dirty <= 1'b1;
            end
        end
    end

    // Active set only changes on the frame boundary so a frame never tears
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_act_digits <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '1;
            r_act_blink  <= '0;
            r_act_lzs    <= 1'b0;
            r_live       <= 1'b0;
        end else if (w_commit) begin
            r_live <= 1'b1;
            if (load) begin
                r_act_digits <= digits;
                r_act_dp     <= dp;
                r_act_blank  <= blank_mask;
                r_act_blink  <= blink_mask;
                r_act_lzs    <= lzs_en;
            end else begin
                r_act_digits <= r_pnd_digits;
                r_act_dp     <= r_pnd_dp;
                r_act_blank  <= r_pnd_blank;
                r_act_blink  <= r_pnd_blink;
                r_act_lzs    <= r_pnd_lzs;
            end
        end
    end

    // Leading zeros from the top digit down, stopping at the first non-zero; digit 0 always shown
    always_comb begin
        w_supp = '0;
        w_lead = r_act_lzs;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (w_lead && (r_act_digits[4*i +: 4] == 4'd0)) begin
                w_supp[i] = 1'b1;
            end else begin
                w_lead = 1'b0;
            end
        end
    end

    // Mux the digit under scan and work out whether it is dark this frame
    always_comb begin
        w_code     = '0;
        w_dp_sel   = 1'b0;
        w_dark_sel = 1'b0;
        w_an_sel   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_scan_idx == IDX_W'(i)) begin
                w_code      = r_act_digits[4*i +: 4];
                w_dp_sel    = r_act_dp[i];
                w_dark_sel  = r_act_blank[i] | (r_act_blink[i] & r_blink_phase) | w_supp[i];
                w_an_sel[i] = 1'b0;
            end
        end
    end

    seg_decode #(
        .HEX_MODE (HEX_MODE)
    ) u_seg_decode (
        .i_code (w_code),
        .o_seg7 (w_seg7)
    );

    // Dark digits keep their anode on so every digit sees the same duty cycle
    always_comb begin
        w_an_next  = '1;
        w_seg_next = SEG_BLANK;
        if (r_live && (r_state == S_DRIVE)) begin
            w_an_next = w_an_sel;
            if (!w_dark_sel) begin
                w_seg_next[6:0]        = w_seg7;
                w_seg_next[SEG_DP_BIT] = ~w_dp_sel;
            end
        end
    end

    // Registered pins: no combinational path from inputs to the display
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - self-checking bench for seven_seg_scanner
module tb_seven_seg_scanner;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  blink;
        logic        lzs;
        logic [31:0] exp_h0;
        logic [31:0] exp_h1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank_mask;
    logic [3:0]  blink_mask;
    logic        lzs_en;
    logic [7:0]  seg_h0, seg_h1;
    logic [3:0]  an_h0, an_h1;
    logic        fd_h0, fd_h1;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic chk_en   = 1'b0;

    vec_t sb_q[$];
    vec_t vecs[9];

    int         m_cnt;
    logic       m_live;
    vec_t       m_act;
    logic [3:0] m_an;
    logic [7:0] m_seg0, m_seg1;
    logic       m_fd;

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1), .BLINK_FRAMES(2), .HEX_MODE(0)
    ) u_dut_h0 (
        .clk(clk), .rst_n(rst_n), .load(load), .digits(digits), .dp(dp),
        .blank_mask(blank_mask), .blink_mask(blink_mask), .lzs_en(lzs_en),
        .seg(seg_h0), .an(an_h0), .frame_done(fd_h0)
    );

    seven_seg_scanner #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1), .BLINK_FRAMES(2), .HEX_MODE(1)
    ) u_dut_h1 (
        .clk(clk), .rst_n(rst_n), .load(load), .digits(digits), .dp(dp),
        .blank_mask(blank_mask), .blink_mask(blink_mask), .lzs_en(lzs_en),
        .seg(seg_h1), .an(an_h1), .frame_done(fd_h1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] d, input logic [3:0] p, input logic [3:0] bl,
                                input logic [3:0] bk, input logic lz,
                                input logic [31:0] e0, input logic [31:0] e1);
        vec_t v;
        v.digits = d; v.dp = p; v.blank = bl; v.blink = bk; v.lzs = lz;
        v.exp_h0 = e0; v.exp_h1 = e1;
        return v;
    endfunction

    // Reference timing model: 4-cycle slots, first cycle dead, 16-cycle frames,
    // blink phase flips every two frames; queued loads are popped at the frame boundary
    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_live <= 1'b0;
            m_act  <= '0;
            m_an   <= 4'hF;
            m_seg0 <= 8'hFF;
            m_seg1 <= 8'hFF;
            m_fd   <= 1'b0;
            sb_q.delete();
        end else begin
            if (!m_live || (m_cnt % 4) == 0) begin
                m_an   <= 4'hF;
                m_seg0 <= 8'hFF;
                m_seg1 <= 8'hFF;
            end else begin
                m_an <= ~(4'b0001 << ((m_cnt / 4) % 4));
                if (m_act.blink[(m_cnt / 4) % 4] && ((m_cnt / 32) % 2) == 1) begin
                    m_seg0 <= 8'hFF;
                    m_seg1 <= 8'hFF;
                end else begin
                    m_seg0 <= m_act.exp_h0[8*((m_cnt / 4) % 4) +: 8];
                    m_seg1 <= m_act.exp_h1[8*((m_cnt / 4) % 4) +: 8];
                end
            end
            m_fd <= ((m_cnt % 16) == 15);
            if ((m_cnt % 16) == 15 && sb_q.size() > 0) begin
                m_act  <= sb_q[$];
                m_live <= 1'b1;
                sb_q.delete();
            end
            m_cnt <= m_cnt + 1;
        end
    end

    // Compare both instances against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("an_h0", 32'(an_h0), 32'(m_an));
            check("an_h1", 32'(an_h1), 32'(m_an));
            check("seg_h0", 32'(seg_h0), 32'(m_seg0));
            check("seg_h1", 32'(seg_h1), 32'(m_seg1));
            check("frame_done_h0", 32'(fd_h0), 32'(m_fd));
            check("frame_done_h1", 32'(fd_h1), 32'(m_fd));
        end
    end

    task automatic drive(input vec_t v);
        digits     = v.digits;
        dp         = v.dp;
        blank_mask = v.blank;
        blink_mask = v.blink;
        lzs_en     = v.lzs;
        load       = 1'b1;
        sb_q.push_back(v);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic align(input int ph);
        for (int k = 0; k < 16 && (m_cnt % 16) != ph; k++) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        vecs[0] = mk(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 32'hF9A4B099, 32'hF9A4B099);
        vecs[1] = mk(16'h00AF, 4'h0, 4'h0, 4'h0, 1'b0, 32'hC0C0FFFF, 32'hC0C0888E);
        vecs[2] = mk(16'h00AF, 4'h0, 4'h0, 4'h0, 1'b1, 32'hFFFFFFFF, 32'hFFFF888E);
        vecs[3] = mk(16'h0000, 4'h4, 4'h0, 4'h0, 1'b1, 32'hFFFFFFC0, 32'hFFFFFFC0);
        vecs[4] = mk(16'h8765, 4'hA, 4'h0, 4'h0, 1'b0, 32'h00F80292, 32'h00F80292);
        vecs[5] = mk(16'h4321, 4'h0, 4'h6, 4'h0, 1'b0, 32'h99FFFFF9, 32'h99FFFFF9);
        vecs[6] = mk(16'h0102, 4'h0, 4'h0, 4'h0, 1'b1, 32'hFFF9C0A4, 32'hFFF9C0A4);
        vecs[7] = mk(16'hBCDE, 4'h1, 4'h0, 4'h0, 1'b0, 32'hFFFFFF7F, 32'h83C6A106);
        vecs[8] = mk(16'h0042, 4'h0, 4'h0, 4'h0, 1'b0, 32'hC0C099A4, 32'hC0C099A4);

        rst_n = 1'b0; load = 1'b0; digits = '0; dp = '0;
        blank_mask = '0; blink_mask = '0; lzs_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_an", 32'(an_h0), 32'hF);
        check("reset_seg", 32'(seg_h0), 32'hFF);
        check("reset_frame_done", 32'(fd_h0), 32'h0);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        idle(40);

        // Table vectors loaded mid-frame; the last one lands exactly on a boundary cycle
        for (int v = 0; v < 8; v++) begin
            align(5);
            drive(vecs[v]);
            idle(40);
        end
        align(15);
        drive(vecs[8]);
        idle(40);

        // Two loads in one frame: current frame untouched, last one wins next frame
        align(3);
        drive(mk(16'h5555, 4'h0, 4'h0, 4'h0, 1'b0, 32'h92929292, 32'h92929292));
        idle(4);
        drive(mk(16'h9999, 4'h0, 4'h0, 4'h0, 1'b0, 32'h90909090, 32'h90909090));
        idle(40);

        // Blink on digit 0 across eight frames
        align(5);
        drive(mk(16'h1234, 4'h0, 4'h0, 4'h1, 1'b0, 32'hF9A4B099, 32'hF9A4B099));
        idle(16 * 8);

        // Reset mid-slot with a load still pending: dark next cycle, load discarded
        align(5);
        drive(mk(16'h1111, 4'h0, 4'h0, 4'h0, 1'b0, 32'hF9F9F9F9, 32'hF9F9F9F9));
        idle(3);
        rst_n = 1'b0;
        @(negedge clk);
        check("midslot_reset_an", 32'(an_h0), 32'hF);
        check("midslot_reset_seg", 32'(seg_h1), 32'hFF);
        rst_n = 1'b1;
        idle(48);
        check("discarded_load_an", 32'(an_h1), 32'hF);

        // Display recovers on the next load
        align(5);
        drive(vecs[0]);
        idle(40);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
